// File: rtl/adc_pulse_detector.sv
// rtl/adc_pulse_detector.sv - baseline-corrected pulse detector with hysteresis and an event FIFO
// One strobe per sample-valid window drives the FSM; completed pulses are queued in a FWFT FIFO.
module adc_pulse_detector #(
  parameter logic signed [15:0] THRESHOLD  = 16'sd200,
  parameter logic signed [15:0] HYST       = 16'sd50,
  parameter int                 FIFO_DEPTH = 16,
  parameter int                 TS_W       = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_valid,
  input  logic signed [15:0]            sample_data,
  input  logic                          adc_error,
  input  logic signed [15:0]            baseline,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic signed [15:0]            event_peak,
  output logic [7:0]                    event_width,
  output logic [TS_W-1:0]               event_ts,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic signed [16:0] THR_HI = {THRESHOLD[15], THRESHOLD};
  localparam logic signed [16:0] THR_LO = THR_HI - {HYST[15], HYST};

  typedef enum logic {IDLE = 1'b0, IN_PULSE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              sv_q, sv_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic signed [15:0] peak_q, peak_d;
  logic [7:0]        width_q, width_d;
  logic [TS_W-1:0]   start_ts_q, start_ts_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [15:0]       drop_q, drop_d;

  logic signed [15:0] mem_peak_q  [FIFO_DEPTH];
  logic signed [15:0] mem_peak_d  [FIFO_DEPTH];
  logic [7:0]         mem_width_q [FIFO_DEPTH];
  logic [7:0]         mem_width_d [FIFO_DEPTH];
  logic [TS_W-1:0]    mem_ts_q    [FIFO_DEPTH];
  logic [TS_W-1:0]    mem_ts_d    [FIFO_DEPTH];

  logic               strobe;
  logic signed [16:0] diff;
  logic signed [15:0] corr;
  logic               push_req, push, pop, full;

  // Strobe on the rising edge of the sample window; an ADC error swallows it.
  assign strobe = sample_valid & ~sv_q & ~adc_error;
  assign sv_d   = sample_valid;
  assign ts_d   = strobe ? ts_q + {{(TS_W-1){1'b0}}, 1'b1} : ts_q;

  always_comb begin
    diff = {sample_data[15], sample_data} - {baseline[15], baseline};
    if (diff > 17'sd32767)
      corr = 16'sh7fff;
    else if (diff < -17'sd32768)
      corr = 16'sh8000;
    else
      corr = diff[15:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and pulse datapath
  always_comb begin
    state_d    = state_q;
    peak_d     = peak_q;
    width_d    = width_q;
    start_ts_d = start_ts_q;
    if (adc_error) begin
      state_d = IDLE;
    end else if (strobe) begin
      case (state_q)
        IDLE: begin
          if (corr >= THRESHOLD) begin
            state_d    = IN_PULSE;
            peak_d     = corr;
            width_d    = 8'd1;
            start_ts_d = ts_q;
          end
        end
        IN_PULSE: begin
          if (corr < THR_LO) begin
            state_d = IDLE;
          end else begin
            if (corr > peak_q) peak_d = corr;
            if (width_q != 8'hff) width_d = width_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs of the FSM
  always_comb begin
    busy     = (state_q == IN_PULSE);
    push_req = strobe & (state_q == IN_PULSE) & (corr < THR_LO);
  end

  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
  assign full        = (count_q == (PW+1)'(FIFO_DEPTH));
  assign event_valid = (count_q != '0);
  assign push        = push_req & ~full;
  assign pop         = event_valid & event_ready;

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    drop_d = drop_q;
    if (push_req & full & (drop_q != 16'hffff)) drop_d = drop_q + 16'd1;
    mem_peak_d  = mem_peak_q;
    mem_width_d = mem_width_q;
    mem_ts_d    = mem_ts_q;
    if (push) begin
      mem_peak_d[wr_ptr_q]  = peak_q;
      mem_width_d[wr_ptr_q] = width_q;
      mem_ts_d[wr_ptr_q]    = start_ts_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sv_q       <= 1'b0;
      ts_q       <= '0;
      peak_q     <= '0;
      width_q    <= '0;
      start_ts_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
    end else begin
      sv_q       <= sv_d;
      ts_q       <= ts_d;
      peak_q     <= peak_d;
      width_q    <= width_d;
      start_ts_q <= start_ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_peak_q  <= mem_peak_d;
    mem_width_q <= mem_width_d;
    mem_ts_q    <= mem_ts_d;
  end

  assign event_peak  = event_valid ? mem_peak_q[rd_ptr_q]  : '0;
  assign event_width = event_valid ? mem_width_q[rd_ptr_q] : '0;
  assign event_ts    = event_valid ? mem_ts_q[rd_ptr_q]    : '0;
  assign fifo_count  = count_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_adc_pulse_detector.sv
// tb/tb_adc_pulse_detector.sv - randomized and directed bench for adc_pulse_detector
// A queue-based event model runs alongside the DUT and is compared on every cycle.
module tb_adc_pulse_detector;

  localparam int DEPTH = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_valid;
  logic signed [15:0] sample_data;
  logic               adc_error;
  logic signed [15:0] baseline;
  logic               event_valid;
  logic               event_ready;
  logic signed [15:0] event_peak;
  logic [7:0]         event_width;
  logic [31:0]        event_ts;
  logic               busy;
  logic [4:0]         fifo_count;
  logic [15:0]        drop_count;

  adc_pulse_detector #(
    .THRESHOLD(16'sd200), .HYST(16'sd50), .FIFO_DEPTH(DEPTH), .TS_W(32)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .adc_error(adc_error), .baseline(baseline), .event_valid(event_valid),
    .event_ready(event_ready), .event_peak(event_peak), .event_width(event_width),
    .event_ts(event_ts), .busy(busy), .fifo_count(fifo_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          peak;
    int          width;
    logic [31:0] ts;
  } ev_t;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;
  bit rnd_ready_en = 0;
  bit rnd_err_en   = 0;

  ev_t         mq[$];
  bit          m_in;
  int          m_peak, m_width;
  logic [31:0] m_start, m_ts;
  int          m_drop;
  bit          m_prev;

  bit          obs_valid;
  int          obs_peak, obs_width;
  logic [31:0] obs_ts;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one step per clock edge using the inputs the bench drove.
  initial begin
    bit strobe, do_push, was_full, do_pop;
    int corr;
    ev_t e;
    m_in = 0; m_ts = 0; m_drop = 0; m_prev = 0; m_peak = 0; m_width = 0; m_start = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        m_in = 0; m_ts = 0; m_drop = 0; m_prev = 0;
      end else begin
        do_pop   = (mq.size() > 0) && event_ready;
        was_full = (mq.size() == DEPTH);
        do_push  = 0;
        strobe   = sample_valid && !m_prev && !adc_error;
        corr = int'(sample_data) - int'(baseline);
        if (corr > 32767) corr = 32767;
        if (corr < -32768) corr = -32768;
        if (adc_error) begin
          m_in = 0;
        end else if (strobe) begin
          if (!m_in) begin
            if (corr >= 200) begin
              m_in = 1; m_peak = corr; m_width = 1; m_start = m_ts;
            end
          end else if (corr < 150) begin
            do_push = 1; m_in = 0;
            e.peak = m_peak; e.width = m_width; e.ts = m_start;
          end else begin
            if (corr > m_peak) m_peak = corr;
            if (m_width < 255) m_width++;
          end
          m_ts = m_ts + 1;
        end
        if (do_push && was_full && m_drop < 65535) m_drop++;
        if (do_pop) void'(mq.pop_front());
        if (do_push && !was_full) mq.push_back(e);
        m_prev = sample_valid;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("busy", busy, m_in);
        check("fifo_count", fifo_count, mq.size());
        check("drop_count", drop_count, m_drop);
        check("event_valid", event_valid, mq.size() != 0);
        if (mq.size() != 0 && event_valid) begin
          check("head_peak", int'(event_peak), mq[0].peak);
          check("head_width", event_width, mq[0].width);
          check("head_ts", event_ts, mq[0].ts);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_ready_en) event_ready = ($urandom_range(0, 2) == 0);
      if (rnd_err_en)   adc_error   = ($urandom_range(0, 40) == 0);
    end
  end

  task automatic send(input int d, input int hold, input int gap);
    @(negedge clk);
    sample_data  = 16'(d);
    sample_valid = 1'b1;
    @(negedge clk);
    obs_valid = event_valid;
    obs_peak  = int'(event_peak);
    obs_width = event_width;
    obs_ts    = event_ts;
    repeat (hold - 1) @(negedge clk);
    sample_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic check_obs(input string name, input int pk, input int w, input longint ts);
    check({name, "_valid"}, obs_valid, 1);
    check({name, "_peak"}, obs_peak, pk);
    check({name, "_width"}, obs_width, w);
    check({name, "_ts"}, obs_ts, ts);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, event_valid, 0);
    check({name, "_peak"}, int'(event_peak), 0);
    check({name, "_width"}, event_width, 0);
    check({name, "_ts"}, event_ts, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_count"}, fifo_count, 0);
    check({name, "_drop"}, drop_count, 0);
  endtask

  initial begin
    logic [31:0] drained[$];
    int b, d;
    reset = 1'b1; sample_valid = 1'b0; sample_data = '0; adc_error = 1'b0;
    baseline = '0; event_ready = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    check_all_zero("reset");
    reset = 1'b0;

    // Main pulse: corrected 100,300,250,400,100,20
    baseline = 16'sd1000;
    send(1100, 3, 2); send(1300, 3, 2); send(1250, 3, 2); send(1400, 3, 2);
    check("main_no_early_event", obs_valid, 0);
    send(1100, 3, 2);
    check_obs("main", 400, 3, 1);
    send(1020, 3, 2);

    // Hysteresis band
    baseline = 16'sd0;
    send(250, 3, 2); send(160, 3, 2); send(151, 3, 2);
    check("hyst_no_event", obs_valid, 0);
    send(149, 3, 2);
    check_obs("hyst", 250, 3, 6);

    // Long valid window counts as one sample
    send(500, 120, 2);
    send(0, 3, 2);
    check_obs("long", 500, 1, 10);

    // Correction saturation and width saturation
    baseline = -16'sd32768;
    send(32767, 3, 2);
    send(-32768, 3, 2);
    check_obs("sat_peak", 32767, 1, 12);
    baseline = 16'sd0;
    for (int i = 0; i < 300; i++) send(500, 1, 1);
    send(0, 3, 2);
    check_obs("sat_width", 500, 255, 14);

    // Overflow: 18 pulses into a 16-deep FIFO
    event_ready = 1'b0;
    for (int k = 0; k < 18; k++) begin
      send(500, 2, 2);
      send(0, 2, 2);
    end
    @(negedge clk);
    check("ovf_count", fifo_count, 16);
    check("ovf_drop", drop_count, 2);
    for (int i = 0; i < 40 && event_valid; i++) begin
      drained.push_back(event_ts);
      event_ready = 1'b1;
      @(negedge clk);
      event_ready = 1'b0;
    end
    check("drain_n", drained.size(), 16);
    for (int k = 0; k < 16 && k < drained.size(); k++)
      check($sformatf("drain_ts%0d", k), drained[k], 315 + 2 * k);

    // ADC error aborts an in-progress pulse
    event_ready = 1'b1;
    send(500, 3, 2);
    check("err_busy_before", busy, 1);
    @(negedge clk); adc_error = 1'b1;
    @(negedge clk); adc_error = 1'b0;
    check("err_busy_after", busy, 0);
    send(0, 3, 2);
    check("err_no_event", obs_valid, 0);
    send(500, 3, 2);
    send(0, 3, 2);
    check_obs("err_next", 500, 1, 353);

    // Random traffic
    rnd_ready_en = 1; rnd_err_en = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = int'($signed(16'($urandom)));
        d = int'($signed(16'($urandom)));
      end else begin
        b = int'($urandom_range(0, 4000)) - 2000;
        d = b + int'($urandom_range(0, 400)) - 50;
      end
      baseline = 16'(b);
      send(d, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
    end
    rnd_ready_en = 0; rnd_err_en = 0;
    @(negedge clk);
    adc_error = 1'b0; event_ready = 1'b1;
    repeat (DEPTH + 4) @(negedge clk);

    // Reset in the middle of a pulse with a queued event
    event_ready = 1'b0;
    baseline = 16'sd0;
    send(500, 2, 2); send(0, 2, 2); send(500, 2, 2);
    check("mid_busy", busy, 1);
    check("mid_count", fifo_count, 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
